sisc_fetch_unit: RTL and testbench

Instruction-fetch stage directly upstream of the SISC control FSM. It owns the PC and the instruction register. It applies the PC and IR control strobes the FSM emits (pc_write, pc_sel, br_sel, pc_rst, ir_load). It decodes opcode/mm back to the FSM and presents IR fields to the datapath. Instruction memory is reached through a variable-latency req/ack handshake; fetch_busy tells the FSM to hold in fetch until the IR is valid.

---
 rtl/sisc_pkg.sv | 31 +++
 rtl/sisc_pc_next.sv | 34 +++
 rtl/sisc_fetch_unit.sv | 181 ++++++++++++++++++
 tb/tb_sisc_fetch_unit.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/sisc_pkg.sv
// SISC shared definitions: opcodes, addressing modes, IR fields, fetch states.
// Optional prefetch buffer in the fetch unit: define SISC_FETCH_PREFETCH_EN.
package sisc_pkg;

  localparam logic [3:0] OP_NOOP = 4'h0;
  localparam logic [3:0] OP_LD   = 4'h1;
  localparam logic [3:0] OP_ST   = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_SUB  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_OR   = 4'h6;
  localparam logic [3:0] OP_XOR  = 4'h7;
  localparam logic [3:0] OP_BRA  = 4'h8;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [3:0] AM_IMM  = 4'h1;

  localparam int IR_OP_HI  = 31;
  localparam int IR_OP_LO  = 28;
  localparam int IR_MM_HI  = 27;
  localparam int IR_MM_LO  = 24;
  localparam int IR_IMM_HI = 15;
  localparam int IR_IMM_LO = 0;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_REQ  = 2'd1,
    F_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sisc_pc_next.sv
// SISC next-PC selection: reset, increment, absolute or relative branch.
// All arithmetic wraps modulo 2^ADDR_W.
module sisc_pc_next #(
  parameter int              ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [15:0]       imm_i,
  input  logic              pc_rst_i,
  input  logic              pc_write_i,
  input  logic              pc_sel_i,
  input  logic              br_sel_i,
  output logic [ADDR_W-1:0] pc_nxt_o
);

  logic [ADDR_W-1:0] imm_sx;
  logic [ADDR_W-1:0] imm_zx;

  assign imm_sx = ADDR_W'(signed'(imm_i));
  assign imm_zx = ADDR_W'(imm_i);

  always_comb begin
    pc_nxt_o = pc_i;
    if (pc_rst_i)
      pc_nxt_o = RESET_PC;
    else if (pc_write_i && !pc_sel_i)
      pc_nxt_o = pc_i + ADDR_W'(1);
    else if (pc_write_i && br_sel_i)
      pc_nxt_o = imm_zx;
    else if (pc_write_i)
      pc_nxt_o = pc_i + imm_sx;
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction fetch: PC, IR and req/ack instruction-memory port.
// Define SISC_FETCH_PREFETCH_EN for a one-entry prefetch buffer.
import sisc_pkg::*;

module sisc_fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               pc_rst,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               ir_load,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ack,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm,
  output logic [ADDR_W-1:0]  pc,
  output logic               ir_valid,
  output logic               fetch_busy
);

  fetch_state_e       state_q;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic               req_q, valid_q, busy_q;

  assign imem_req   = req_q;
  assign imem_addr  = addr_q;
  assign ir         = ir_q;
  assign ir_valid   = valid_q;
  assign fetch_busy = busy_q;
  assign pc         = pc_q;
  assign opcode     = ir_q[IR_OP_HI:IR_OP_LO];
  assign mm         = ir_q[IR_MM_HI:IR_MM_LO];
  assign imm        = ir_q[IR_IMM_HI:IR_IMM_LO];

  sisc_pc_next #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_next (
    .pc_i       (pc_q),
    .imm_i      (imm),
    .pc_rst_i   (pc_rst),
    .pc_write_i (pc_write),
    .pc_sel_i   (pc_sel),
    .br_sel_i   (br_sel),
    .pc_nxt_o   (pc_d)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

`ifdef SISC_FETCH_PREFETCH_EN
  logic [ADDR_W-1:0]  pf_addr_q, dem_addr_q;
  logic [INSTR_W-1:0] pf_data_q;
  logic               pf_valid_q, pf_req_q, pf_drop_q;
  logic               pf_inv, pf_hit;

  assign pf_inv = pc_rst | (pc_write & pc_sel);
  assign pf_hit = pf_valid_q && (pf_addr_q == pc_q);

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q    <= F_IDLE;
      addr_q     <= '0;
      ir_q       <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      pf_addr_q  <= '0;
      dem_addr_q <= '0;
      pf_data_q  <= '0;
      pf_valid_q <= 1'b0;
      pf_req_q   <= 1'b0;
      pf_drop_q  <= 1'b0;
    end else begin
      unique case (state_q)
        F_IDLE, F_DONE: begin
          if (ir_load && pf_hit) begin
            ir_q       <= pf_data_q;
            valid_q    <= 1'b1;
            pf_valid_q <= 1'b0;
            state_q    <= F_DONE;
          end else if (ir_load) begin
            valid_q    <= 1'b0;
            busy_q     <= 1'b1;
            dem_addr_q <= pc_q;
            state_q    <= F_REQ;
            if (!req_q) begin
              req_q  <= 1'b1;
              addr_q <= pc_q;
            end
          end
          if (req_q && imem_ack) begin
            req_q     <= 1'b0;
            pf_req_q  <= 1'b0;
            pf_drop_q <= 1'b0;
            if (!pf_drop_q) begin
              pf_data_q  <= imem_rdata;
              pf_addr_q  <= addr_q;
              pf_valid_q <= 1'b1;
            end
          end else if (!req_q && state_q == F_DONE && !ir_load && !pf_hit) begin
            req_q    <= 1'b1;
            addr_q   <= pc_q;
            pf_req_q <= 1'b1;
          end
        end
        F_REQ: begin
          // a prefetch may own the port; a stale one is retired then reissued
          if (!req_q) begin
            req_q    <= 1'b1;
            addr_q   <= dem_addr_q;
            pf_req_q <= 1'b0;
          end else if (imem_ack) begin
            req_q     <= 1'b0;
            pf_req_q  <= 1'b0;
            pf_drop_q <= 1'b0;
            if (addr_q == dem_addr_q) begin
              ir_q    <= imem_rdata;
              valid_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= F_DONE;
            end
          end
        end
        default: state_q <= F_IDLE;
      endcase
      if (pf_inv) begin
        pf_valid_q <= 1'b0;
        if (pf_req_q && !imem_ack) pf_drop_q <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= F_IDLE;
      addr_q  <= '0;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        F_IDLE, F_DONE: begin
          if (ir_load) begin
            addr_q  <= pc_q;
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            valid_q <= 1'b0;
            state_q <= F_REQ;
          end
        end
        F_REQ: begin
          if (imem_ack) begin
            ir_q    <= imem_rdata;
            req_q   <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
            state_q <= F_DONE;
          end
        end
        default: state_q <= F_IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Directed bench for sisc_fetch_unit with a small instruction-memory model.
// Second instance with RESET_PC=0xFFFF exercises PC wrap.
`timescale 1ns/1ps
module tb_sisc_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_f = 1'b0;
  logic        pc_rst = 1'b0, pc_write = 1'b0;
  logic        pc_sel = 1'b0, br_sel = 1'b0;
  logic        ir_load = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] ir;
  logic [3:0]  opcode, mm;
  logic [15:0] imm, pc;
  logic        ir_valid, fetch_busy;

  logic        ack_man = 1'b0, ack_auto = 1'b0, auto_en = 1'b0;
  logic        use_junk = 1'b0;
  logic [31:0] mem [256];

  logic        w_req, w_valid, w_busy;
  logic [15:0] w_addr, w_imm, w_pc;
  logic [31:0] w_ir;
  logic [3:0]  w_op, w_mm;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign imem_ack   = ack_man | ack_auto;
  assign imem_rdata = use_junk ? 32'hDEAD_BEEF : mem[imem_addr[7:0]];

  always @(negedge clk)
    ack_auto <= auto_en && imem_req && !ack_auto;

  sisc_fetch_unit dut (
    .clk(clk), .rst_f(rst_f), .pc_rst(pc_rst), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(ir_load),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .ir(ir), .opcode(opcode), .mm(mm), .imm(imm), .pc(pc),
    .ir_valid(ir_valid), .fetch_busy(fetch_busy)
  );

  sisc_fetch_unit #(.RESET_PC(16'hFFFF)) dut_w (
    .clk(clk), .rst_f(rst_f), .pc_rst(1'b0), .pc_write(pc_write),
    .pc_sel(pc_sel), .br_sel(br_sel), .ir_load(1'b0),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_rdata(32'h0), .imem_ack(1'b0),
    .ir(w_ir), .opcode(w_op), .mm(w_mm), .imm(w_imm), .pc(w_pc),
    .ir_valid(w_valid), .fetch_busy(w_busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pcw(input logic sel, input logic br);
    pc_write = 1'b1; pc_sel = sel; br_sel = br;
    step();
    pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a, input int lat);
    ir_load = 1'b1;
    step();
    ir_load = 1'b0;
    check("req_up", 32'(imem_req), 32'd1);
    check("req_addr", 32'(imem_addr), 32'(a));
    check("busy_up", 32'(fetch_busy), 32'd1);
    check("valid_lo", 32'(ir_valid), 32'd0);
    repeat (lat) step();
    ack_man = 1'b1;
    step();
    ack_man = 1'b0;
    check("valid_up", 32'(ir_valid), 32'd1);
    check("req_dn", 32'(imem_req), 32'd0);
    check("busy_dn", 32'(fetch_busy), 32'd0);
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      if (ir_valid) break;
      step();
    end
    check("valid_wait", 32'(ir_valid), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]     = 32'h8100_0005;
    mem[1]     = 32'h8100_0010;
    mem[3]     = 32'h8100_0020;
    mem[4]     = 32'h1234_5678;
    mem[8'h10] = 32'h8000_FFFC;
    mem[8'h20] = 32'hF000_0000;

    step(); step();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_ir", ir, 32'h0);
    check("rst_valid", 32'(ir_valid), 32'd0);
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'h0);
    check("rst_busy", 32'(fetch_busy), 32'd0);
    check("rst_wpc", 32'(w_pc), 32'hFFFF);
    rst_f = 1'b1;
    step();

`ifdef SISC_FETCH_PREFETCH_EN
    auto_en = 1'b1;
    ir_load = 1'b1; step(); ir_load = 1'b0;
    wait_valid(10);
    check("pf_ir0", ir, 32'h8100_0005);
    pcw(1'b0, 1'b0);
    repeat (8) step();
    ir_load = 1'b1; step(); ir_load = 1'b0;
    check("pf_hit_valid", 32'(ir_valid), 32'd1);
    check("pf_hit_ir", ir, 32'h8100_0010);
    check("pf_hit_noreq", 32'(imem_req), 32'd0);
    pcw(1'b1, 1'b1);
    check("pf_br_pc", 32'(pc), 32'h0010);
    ir_load = 1'b1; step(); ir_load = 1'b0;
    check("pf_miss_busy", 32'(fetch_busy), 32'd1);
    wait_valid(12);
    check("pf_miss_ir", ir, 32'h8000_FFFC);
    auto_en = 1'b0;
`else
    fetch(16'h0000, 3);
    check("f0_ir", ir, 32'h8100_0005);
    check("f0_op", 32'(opcode), 32'h8);
    check("f0_mm", 32'(mm), 32'h1);
    check("f0_imm", 32'(imm), 32'h5);

    pcw(1'b0, 1'b0);
    check("inc_pc", 32'(pc), 32'h0001);
    check("wrap_rst", 32'(w_pc), 32'h0000);

    fetch(16'h0001, 0);
    check("f1_ir", ir, 32'h8100_0010);
    pcw(1'b1, 1'b1);
    check("abs_10", 32'(pc), 32'h0010);

    fetch(16'h0010, 1);
    check("f10_imm", 32'(imm), 32'hFFFC);
    check("f10_mm", 32'(mm), 32'h0);
    pcw(1'b1, 1'b0);
    check("rel_neg", 32'(pc), 32'h000C);
    repeat (4) pcw(1'b0, 1'b0);
    check("back_10", 32'(pc), 32'h0010);
    pcw(1'b1, 1'b1);
    check("abs_fffc", 32'(pc), 32'hFFFC);
    repeat (4) pcw(1'b0, 1'b0);
    check("wrap_inc", 32'(pc), 32'h0000);

    pc_write = 1'b1; pc_rst = 1'b1;
    step();
    pc_write = 1'b0; pc_rst = 1'b0;
    check("rst_prio", 32'(pc), 32'h0000);

    repeat (3) pcw(1'b0, 1'b0);
    fetch(16'h0003, 0);
    check("f3_imm", 32'(imm), 32'h0020);
    pcw(1'b0, 1'b0);
    check("pc_4", 32'(pc), 32'h0004);

    ir_load = 1'b1;
    step();
    pc_write = 1'b1; pc_sel = 1'b1; br_sel = 1'b1;
    step();
    ir_load = 1'b0; pc_write = 1'b0; pc_sel = 1'b0; br_sel = 1'b0;
    check("fly_addr", 32'(imem_addr), 32'h0004);
    check("fly_req", 32'(imem_req), 32'd1);
    check("fly_pc", 32'(pc), 32'h0020);
    ack_man = 1'b1; step(); ack_man = 1'b0;
    check("fly_ir", ir, 32'h1234_5678);
    check("fly_valid", 32'(ir_valid), 32'd1);
    check("fly_pc2", 32'(pc), 32'h0020);

    ir_load = 1'b1; step(); ir_load = 1'b0;
    pc_rst = 1'b1; step(); pc_rst = 1'b0;
    check("prst_pc", 32'(pc), 32'h0000);
    check("prst_addr", 32'(imem_addr), 32'h0020);
    ack_man = 1'b1; step(); ack_man = 1'b0;
    check("prst_ir", ir, 32'hF000_0000);
    check("prst_valid", 32'(ir_valid), 32'd1);
    check("prst_op", 32'(opcode), 32'hF);

    use_junk = 1'b1; ack_man = 1'b1; step();
    use_junk = 1'b0; ack_man = 1'b0;
    check("done_ack_ir", ir, 32'hF000_0000);
    check("done_ack_req", 32'(imem_req), 32'd0);

    ir_load = 1'b1; step(); ir_load = 1'b0;
    check("mid_req", 32'(imem_req), 32'd1);
    rst_f = 1'b0;
    #1;
    check("async_req", 32'(imem_req), 32'd0);
    check("async_ir", ir, 32'h0);
    check("async_valid", 32'(ir_valid), 32'd0);
    step();
    rst_f = 1'b1;
    step();
    use_junk = 1'b1; ack_man = 1'b1; step();
    use_junk = 1'b0; ack_man = 1'b0;
    check("stray_ir", ir, 32'h0);
    check("stray_valid", 32'(ir_valid), 32'd0);
    check("stray_busy", 32'(fetch_busy), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
